// File: rtl/systolic_mem_arbiter.sv
// systolic_mem_arbiter
// Shares one single-port operand/result memory between the systolic array
// controller (port 0) and the host/loader path (port 1). One access is granted
// per cycle, locked bursts keep ownership with one port, and every read return
// is steered back to the port that issued it.
// Optional build macro: SYS_ARB_FIXED_PRIO_EN -- when defined, IDLE ties always
// go to port 0 and the round-robin pointer is removed.

module systolic_mem_arbiter #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   pick1;
    logic   issue_read;

    // Return pipeline: one {valid, port} slot per cycle of memory latency.
    logic [READ_LAT-1:0] vld_pipe;
    logic [READ_LAT-1:0] port_pipe;
    logic                ret_valid;
    logic                ret_port;

`ifndef SYS_ARB_FIXED_PRIO_EN
    // 1 = port 1 received the most recent grant; ties go to the other port.
    logic last;

    // Remember which port was granted most recently for round-robin ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last <= gnt1;
        end
    end
`endif

    // FSM state register; reset releases any lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant decision and next state; nothing is granted while reset is held.
    always_comb begin
        next_state = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
`ifdef SYS_ARB_FIXED_PRIO_EN
        pick1      = 1'b0;
`else
        pick1      = ~last;
`endif
        if (rst) begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || !pick1)) begin
                        gnt0 = 1'b1;
                        if (lock0) next_state = LOCK0;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                        if (lock1) next_state = LOCK1;
                    end
                end
                LOCK0: begin
                    if (req0) begin
                        gnt0 = 1'b1;
                        if (!lock0) next_state = IDLE;
                    end else begin
                        next_state = IDLE;
                    end
                end
                LOCK1: begin
                    if (req1) begin
                        gnt1 = 1'b1;
                        if (!lock1) next_state = IDLE;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Memory-side mux; with no grant port 0 drives address/data but never writes.
    always_comb begin
        mem_addr   = gnt1 ? addr1  : addr0;
        mem_wdata  = gnt1 ? wdata1 : wdata0;
        mem_we     = (gnt0 & we0) | (gnt1 & we1);
        issue_read = (gnt0 & ~we0) | (gnt1 & ~we1);
    end

    generate
        if (READ_LAT > 1) begin : g_deep_pipe
            // Carry each granted read's tag alongside the memory latency.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_pipe  <= '0;
                    port_pipe <= '0;
                end else begin
                    vld_pipe  <= {vld_pipe[READ_LAT-2:0], issue_read};
                    port_pipe <= {port_pipe[READ_LAT-2:0], gnt1};
                end
            end
        end else begin : g_short_pipe
            // Single-cycle latency needs only one tag slot.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_pipe  <= '0;
                    port_pipe <= '0;
                end else begin
                    vld_pipe  <= issue_read;
                    port_pipe <= gnt1;
                end
            end
        end
    endgenerate

    assign ret_valid = vld_pipe[READ_LAT-1];
    assign ret_port  = port_pipe[READ_LAT-1];

    // Capture returning data into the issuing port and pulse its rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= ret_valid & ~ret_port;
            rvalid1 <= ret_valid & ret_port;
            if (ret_valid && !ret_port) rdata0 <= mem_rdata;
            if (ret_valid && ret_port)  rdata1 <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_systolic_mem_arbiter.sv
// tb_systolic_mem_arbiter
// Drives both requester ports against a behavioural memory, checks grants and
// the memory strobe every cycle, and scores read returns (port, data, cycle)
// against a queue filled when each read is granted.

module tb_systolic_mem_arbiter;

    localparam int LAT = 1;
`ifdef SYS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        int          port;
        logic [15:0] data;
        int          cyc;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [11:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem     [0:4095];
    logic [15:0] exp_mem [0:4095];
    logic [15:0] rd_pipe [0:LAT-1];

    ret_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n0, n1;
    logic eg1;

    systolic_mem_arbiter #(.WIDTH(16), .ADDR_W(12), .READ_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to check return latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory with LAT cycles of read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Score every read return as it appears.
    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            if (rvalid0 && rvalid1) checkOutput("rvalid_both", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                checkOutput("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                ret_t e;
                e = sb.pop_front();
                checkOutput("ret_port", rvalid1 ? 32'd1 : 32'd0, 32'(e.port));
                checkOutput("ret_data", e.port == 1 ? 32'(rdata1) : 32'(rdata0), 32'(e.data));
                checkOutput("ret_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic applyStimulus(
        input logic r0, input logic w0, input logic l0, input logic [11:0] a0, input logic [15:0] d0,
        input logic r1, input logic w1, input logic l1, input logic [11:0] a1, input logic [15:0] d1,
        input logic eg0, input logic eg1x);
        ret_t e;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        checkOutput("gnt0", 32'(gnt0), 32'(eg0));
        checkOutput("gnt1", 32'(gnt1), 32'(eg1x));
        checkOutput("mem_we", 32'(mem_we), 32'((eg0 & w0) | (eg1x & w1)));
        if (eg0) checkOutput("mem_addr0", 32'(mem_addr), 32'(a0));
        if (eg1x) checkOutput("mem_addr1", 32'(mem_addr), 32'(a1));
        if (eg0 && !w0) begin
            e.port = 0; e.data = exp_mem[a0]; e.cyc = cyc + LAT + 1; sb.push_back(e);
        end
        if (eg0 && w0) exp_mem[a0] = d0;
        if (eg1x && !w1) begin
            e.port = 1; e.data = exp_mem[a1]; e.cyc = cyc + LAT + 1; sb.push_back(e);
        end
        if (eg1x && w1) exp_mem[a1] = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 12'h0, 16'h0, 0, 0, 0, 12'h0, 16'h0, 0, 0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_gnt0", 32'(gnt0), 32'd0);
        checkOutput("rst_gnt1", 32'(gnt1), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_rvalid0", 32'(rvalid0), 32'd0);
        checkOutput("rst_rvalid1", 32'(rvalid1), 32'd0);
        checkOutput("rst_rdata0", 32'(rdata0), 32'd0);
        checkOutput("rst_rdata1", 32'(rdata1), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < 4096; i++) begin
            exp_mem[i] = 16'(i * 7 + 3);
            mem[i]    <= 16'(i * 7 + 3);
        end
        exp_mem[12'h010] = 16'h1234;
        mem[12'h010]    <= 16'h1234;

        // Reset values, with requests present that must not be honoured.
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        rst = 1'b1;
        idle(1);

        // Single read from port 0.
        applyStimulus(1, 0, 0, 12'h010, 16'h0, 0, 0, 0, 12'h0, 16'h0, 1, 0);
        idle(3);

        // Both ports read every cycle; port 0 was granted last, so port 1 leads.
        n0 = 0; n1 = 0;
        for (int k = 0; k < 6; k++) begin
            eg1 = FIXED ? 1'b0 : (k % 2 == 0);
            applyStimulus(1, 0, 0, 12'h040 + 12'(n0), 16'h0, 1, 0, 0, 12'h050 + 12'(n1), 16'h0, !eg1, eg1);
            if (eg1) n1++; else n0++;
        end
        idle(2);

        // Port 1 access so port 0 wins the next tie in either build.
        applyStimulus(0, 0, 0, 12'h0, 16'h0, 1, 0, 0, 12'h061, 16'h0, 0, 1);

        // Locked burst of four writes from port 0 with port 1 waiting.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, i < 3, 12'h100 + 12'(i), 16'h8001 + 16'(i * 16'h1111),
                          1, 0, 0, 12'h062, 16'h0, 1, 0);
        applyStimulus(0, 0, 0, 12'h0, 16'h0, 1, 0, 0, 12'h062, 16'h0, 0, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 0, 12'h100 + 12'(i), 16'h0, 0, 0, 0, 12'h0, 16'h0, 1, 0);
        idle(2);

        // Port 1 lock, port 0 ignored, then req1 dropped: bubble, then port 0.
        applyStimulus(0, 0, 0, 12'h0, 16'h0, 1, 0, 1, 12'h070, 16'h0, 0, 1);
        applyStimulus(1, 0, 0, 12'h071, 16'h0, 1, 0, 1, 12'h072, 16'h0, 0, 1);
        applyStimulus(1, 0, 0, 12'h071, 16'h0, 0, 0, 0, 12'h0, 16'h0, 0, 0);
        applyStimulus(1, 0, 0, 12'h071, 16'h0, 0, 0, 0, 12'h0, 16'h0, 1, 0);
        idle(2);

        // Port 1 writes -2, port 0 reads it back the next cycle.
        applyStimulus(0, 0, 0, 12'h0, 16'h0, 1, 1, 0, 12'h020, 16'hFFFE, 0, 1);
        applyStimulus(1, 0, 0, 12'h020, 16'h0, 0, 0, 0, 12'h0, 16'h0, 1, 0);
        idle(3);

        // Locked port 1 read in flight when reset hits.
        applyStimulus(0, 0, 0, 12'h0, 16'h0, 1, 0, 1, 12'h030, 16'h0, 0, 1);
        rst = 1'b0;
        sb.delete();
        req0 = 1; req1 = 1; lock1 = 1;
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1;
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0 = 0; req1 = 0; lock1 = 0;
        // Lock released and pointer back at 1: the tie goes to port 0.
        applyStimulus(1, 0, 0, 12'h031, 16'h0, 1, 0, 0, 12'h032, 16'h0, 1, 0);
        idle(4);

        // Drain outstanding returns with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_mem_arbiter.md
# systolic_mem_arbiter

Two-requester arbiter that shares the single-port operand/result memory (12-bit address, WIDTH-bit data) between the systolic array controller (port 0) and the host/loader path (port 1). It grants one access per cycle, supports locked bursts so a streaming requester keeps ownership, and routes each read return to the port that issued the read. It sits between the array controller's `mem_read`/`mem_write`/`act_addr` path and the memory macro.

## Interface
- `WIDTH`, 16, data width of memory words (signed two's complement, passed through untouched)
- `ADDR_W`, 12, memory address width
- `READ_LAT`, 1, memory read latency in cycles (1..4)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req0`, `req1`  in  1  access request per port
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled with req
- `lock0`, `lock1`  in  1  hold ownership after this grant
- `addr0`, `addr1`  in  ADDR_W  access address
- `wdata0`, `wdata1`  in  WIDTH  write data
- `gnt0`, `gnt1`  out  1  access accepted this cycle (combinational from state and req)
- `rvalid0`, `rvalid1`  out  1  registered one-cycle pulse, read data valid
- `rdata0`, `rdata1`  out  WIDTH  registered read data, held until next rvalid on that port
- `mem_addr`  out  ADDR_W  address to memory
- `mem_we`  out  1  write strobe to memory
- `mem_wdata`  out  WIDTH  write data to memory
- `mem_rdata`  in  WIDTH  memory read data, valid READ_LAT cycles after address

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Reset state IDLE.
- IDLE: a single requesting port is granted. If both request, arbitration picks the winner (round-robin: port not granted last; `last` pointer resets to 1, so port 0 wins the first tie).
- A grant with lockK=1 moves the FSM to LOCKK at the next edge; a grant with lockK=0 keeps it in IDLE.
- LOCKK: only port K may be granted; the other port's req is ignored (gnt=0). Stay while reqK && lockK. If reqK=1 and lockK=0, grant this final access, then go to IDLE. If reqK=0, no grant that cycle, go to IDLE (one-cycle bubble).
- At most one of gnt0/gnt1 is high in any cycle. `last` updates on every grant.
- Memory side: mem_addr/mem_wdata/mem_we are a combinational mux of the granted port; with no grant, mem_we=0 and mem_addr/mem_wdata = port 0's values (don't-care, never a write).
- Read return: a READ_LAT-deep shift register carries {valid, port} for each granted read; when it emerges, mem_rdata is captured into rdataK and rvalidK pulses for one cycle.
- Writes produce no rvalid. Back-to-back reads from alternating ports return in issue order.

## Timing
- Grant cycle t: gnt and mem_* valid in t; mem_rdata valid in t+READ_LAT; rvalidK/rdataK visible in t+READ_LAT+1.
- Throughput: one access per cycle, including while switching ports from IDLE.
- Reset values: gnt0/1=0 (no req honored during reset), rvalid0/1=0, rdata0/1=0, mem_we=0, FSM=IDLE, return pipeline cleared, last=1.
- Reset asserted mid-burst or with reads in flight: lock released, in-flight reads dropped, no rvalid after deassertion.
- Simultaneous req from both ports while LOCKK exits via lockK=0: only port K granted that cycle; the other port is granted at the earliest next cycle.
- req dropped without gnt: request is withdrawn, nothing issued; requesters must hold req/we/addr/wdata stable until gnt.

## Configuration
- `SYS_ARB_FIXED_PRIO_EN` defined: IDLE ties always go to port 0 (array controller has strict priority); `last` pointer removed. Lock behaviour unchanged.
- Not defined: round-robin ties as described above.

## Test plan
- Single read port 0, addr 0x010, memory holds 0x1234, READ_LAT=1 -> gnt0 in cycle t, rvalid0=1 with rdata0=0x1234 in t+2, rvalid1 never.
- Both ports read every cycle, no lock, round-robin -> grants alternate 0,1,0,1; returns routed to correct port in issue order; with `SYS_ARB_FIXED_PRIO_EN` only port 0 granted.
- Port 0 locked burst of 4 writes (addr 0x100..0x103, lock0=1 on first 3) while req1 held -> gnt0 four cycles, gnt1=0 throughout, gnt1 on the next cycle; memory contains the 4 words.
- LOCK1 with req1 dropped -> no grant that cycle, FSM IDLE, pending req0 granted next cycle.
- Reset (rst=0) asserted one cycle after a port 1 read grant with READ_LAT=3 -> all outputs return to reset values, no rvalid1 after release, FSM IDLE.
- Write 0xFFFE to 0x020 by port 1 then read by port 0 next cycle -> rdata0=0xFFFE (-2), mem_we high only in the write cycle.
